// File: rtl/bus_cycle_controller_if.sv
// Bus-side signal bundle for bus_cycle_controller.
// Handshake: cpu_ready is the only flow-control signal toward the CPU. A
// cycle advances out of T3/TW on the clock where cpu_ready is high. The
// controller holds cpu_ready low for wait states, for io_channel_ready low,
// and while the bus is granted to DMA. bus_hold_request/bus_hold_acknowledge
// form a level handshake: acknowledge rises only from IDLE, and it stays high
// until the request drops.
interface bus_cycle_controller_if;
  logic [2:0]  cpu_status;
  logic [19:0] cpu_address;
  logic        io_channel_ready;
  logic        bus_hold_request;
  logic        bus_hold_acknowledge;
  logic [19:0] address;
  logic        address_latch_enable;
  logic        address_enable_n;
  logic        io_read_n;
  logic        io_write_n;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        interrupt_acknowledge_n;
  logic        data_bus_direction;
  logic        cpu_ready;

  // Controller side: owns the commands and the latched address.
  modport master (
    input  cpu_status, cpu_address, io_channel_ready, bus_hold_request,
    output bus_hold_acknowledge, address, address_latch_enable,
           address_enable_n, io_read_n, io_write_n, memory_read_n,
           memory_write_n, interrupt_acknowledge_n, data_bus_direction,
           cpu_ready
  );

  // CPU / peripheral / DMA side.
  modport slave (
    output cpu_status, cpu_address, io_channel_ready, bus_hold_request,
    input  bus_hold_acknowledge, address, address_latch_enable,
           address_enable_n, io_read_n, io_write_n, memory_read_n,
           memory_write_n, interrupt_acknowledge_n, data_bus_direction,
           cpu_ready
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// 8288-style bus command generator. It decodes the CPU status S2..S0 into a
// T1..T4 bus cycle and drives the latched address and the active-low
// command strobes. It inserts wait states through cpu_ready, and it grants
// the bus to DMA between CPU cycles.
module bus_cycle_controller #(
  parameter logic [2:0] io_wait_states     = 3'd1,
  parameter logic [2:0] memory_wait_states = 3'd0
) (
  input  logic                          clock,
  input  logic                          reset,
  bus_cycle_controller_if.master        bus,
  output logic [2:0]                    state_debug
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TW   = 3'd4,
    T4   = 3'd5,
    HOLD = 3'd6
  } state_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;
  localparam logic [2:0] STATUS_HALT    = 3'b011;
  localparam logic [4:0] CMD_NONE       = 5'b11111;

  state_t      state;
  logic [2:0]  cycle_type;
  logic [2:0]  wait_count;
  logic        passive_seen;
  logic [19:0] address_q;
  logic        ale_q;
  logic        ack_q;
  logic        dir_q;
  // Command strobes packed as {inta_n, ior_n, iow_n, memr_n, memw_n}.
  logic [4:0]  cmd_n_q;
  logic        cycle_start;
  logic        wait_done;

  // Strobe pattern for a cycle type; CODE fetches share memory_read_n.
  function automatic logic [4:0] command_for(input logic [2:0] t);
    case (t)
      3'b000:  return 5'b01111;
      3'b001:  return 5'b10111;
      3'b010:  return 5'b11011;
      3'b100:  return 5'b11101;
      3'b101:  return 5'b11101;
      3'b110:  return 5'b11110;
      default: return CMD_NONE;
    endcase
  endfunction

  // Cycles whose data flows toward the CPU: INTA, IOR, CODE, MEMR.
  function automatic logic toward_cpu(input logic [2:0] t);
    return (t == 3'b000) || (t == 3'b001) || (t == 3'b100) || (t == 3'b101);
  endfunction

  // A new cycle needs a passive status since the last T1. This also blocks
  // a stale status from restarting a cycle after a mid-cycle reset.
  assign cycle_start = passive_seen &&
                       (bus.cpu_status != STATUS_PASSIVE) &&
                       (bus.cpu_status != STATUS_HALT);
  assign wait_done   = (wait_count == 3'd0) && bus.io_channel_ready;

  // Bus cycle sequencer with registered strobes, address latch and hold grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cycle_type   <= STATUS_PASSIVE;
      wait_count   <= 3'd0;
      passive_seen <= 1'b0;
      address_q    <= 20'd0;
      ale_q        <= 1'b0;
      ack_q        <= 1'b0;
      dir_q        <= 1'b0;
      cmd_n_q      <= CMD_NONE;
    end else begin
      if (bus.cpu_status == STATUS_PASSIVE) passive_seen <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.bus_hold_request) begin
            state <= HOLD;
            ack_q <= 1'b1;
          end else if (cycle_start) begin
            state        <= T1;
            cycle_type   <= bus.cpu_status;
            address_q    <= bus.cpu_address;
            ale_q        <= 1'b1;
            dir_q        <= toward_cpu(bus.cpu_status);
            passive_seen <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.bus_hold_request) begin
            state <= IDLE;
            ack_q <= 1'b0;
          end
        end
        T1: begin
          state      <= T2;
          ale_q      <= 1'b0;
          // Status codes with S2 low are INTA/IOR/IOW; HALT never gets here.
          wait_count <= cycle_type[2] ? memory_wait_states : io_wait_states;
          cmd_n_q    <= command_for(cycle_type);
        end
        T2: state <= T3;
        T3, TW: begin
          if (wait_done) begin
            state   <= T4;
            cmd_n_q <= CMD_NONE;
          end else begin
            state <= TW;
            if (wait_count != 3'd0) wait_count <= wait_count - 3'd1;
          end
        end
        T4: begin
          state <= IDLE;
          dir_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready = !(((state == T3) || (state == TW)) && !wait_done) &&
                         (state != HOLD);

  assign bus.address                 = address_q;
  assign bus.address_latch_enable    = ale_q;
  assign bus.bus_hold_acknowledge    = ack_q;
  // Address drivers are disabled while DMA owns the bus.
  assign bus.address_enable_n        = ack_q;
  assign bus.interrupt_acknowledge_n = cmd_n_q[4];
  assign bus.io_read_n               = cmd_n_q[3];
  assign bus.io_write_n              = cmd_n_q[2];
  assign bus.memory_read_n           = cmd_n_q[1];
  assign bus.memory_write_n          = cmd_n_q[0];
  assign bus.data_bus_direction      = dir_q;
  assign state_debug                 = state;

endmodule
